// File: rtl/abc_vec_pkg.sv
// Shared types and helpers for the abc_vec_fifo slice.
//   fsm_e      : serial emitter states (IDLE, EMIT)
//   clog2_min1 : ceil(log2(n)), never below 1, so index ports stay at least 1 bit
//   ABC_*_DFLT : default vector geometry (6 lanes x 32 bits)
package abc_vec_pkg;

    localparam int ABC_NUM_LANES_DFLT = 6;
    localparam int ABC_LANE_W_DFLT    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } fsm_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/abc_vec_fifo_lane_pick.sv
// Combinational lane finder for a lane-enable mask.
//   mask      : lane-enable mask to search
//   start_idx : search origin
//   incl      : 1 = start_idx itself may match, 0 = search strictly above it
//   found     : a set bit was found
//   idx       : lowest matching lane (0 when none)
//   is_last   : no set bit in mask above idx
module abc_lane_pick
    import abc_vec_pkg::*;
#(
    parameter  int NUM_LANES = ABC_NUM_LANES_DFLT,
    localparam int IW        = clog2_min1(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] mask,
    input  logic [IW-1:0]        start_idx,
    input  logic                 incl,
    output logic                 found,
    output logic [IW-1:0]        idx,
    output logic                 is_last
);

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        is_last = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && mask[i] &&
                ((incl && (i >= int'(start_idx))) || (!incl && (i > int'(start_idx))))) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (found && mask[i] && (i > int'(idx))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/abc_vec_fifo.sv
// Valid/ready FIFO of [NUM_LANES][LANE_W] vectors with a per-entry lane mask.
// SERIAL_OUT=0 emits one masked vector per beat; SERIAL_OUT=1 emits one
// enabled lane per beat (out_lane_idx/out_lane_data, out_last on the final lane).
//   ck, rst_n                     : clock, synchronous active-low reset
//   in_valid/in_ready             : producer handshake, in_data + in_lane_en
//   out_valid/out_ready           : consumer handshake
//   out_data, out_lane_en         : head vector (masked) and its mask
//   out_lane_data, out_lane_idx   : current lane in serial mode
//   out_last                      : final beat of the head entry
//   level                         : entries stored
//
// Serial emitter states:
//   state | meaning
//   IDLE  | FIFO empty, nothing presented
//   EMIT  | presenting lane lane_q of the head entry
module abc_vec_fifo
    import abc_vec_pkg::*;
#(
    parameter  int NUM_LANES  = ABC_NUM_LANES_DFLT,
    parameter  int LANE_W     = ABC_LANE_W_DFLT,
    parameter  int DEPTH      = 4,
    parameter  int SERIAL_OUT = 0,
    localparam int IW         = clog2_min1(NUM_LANES),
    localparam int PW         = clog2_min1(DEPTH),
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic                              ck,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]  in_data,
    input  logic [NUM_LANES-1:0]              in_lane_en,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_LANES-1:0][LANE_W-1:0]  out_data,
    output logic [NUM_LANES-1:0]              out_lane_en,
    output logic [LANE_W-1:0]                 out_lane_data,
    output logic [IW-1:0]                     out_lane_idx,
    output logic                              out_last,
    output logic [LW-1:0]                     level
);

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] vec_t;

    vec_t                 data_mem [DEPTH];
    logic [NUM_LANES-1:0] mask_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic                 push;
    logic                 push_store;
    logic                 pop;
    vec_t                 head_data;
    logic [NUM_LANES-1:0] head_mask;

    // No full bypass: a same-cycle pop does not open in_ready.
    assign in_ready   = (level_q != LW'(DEPTH));
    assign push       = in_valid & in_ready;
    // In serial mode an all-zero mask has nothing to emit, so it is swallowed.
    assign push_store = push & ((SERIAL_OUT == 0) | (|in_lane_en));
    assign head_data  = data_mem[rd_ptr_q];
    assign head_mask  = mask_mem[rd_ptr_q];
    assign level      = level_q;

    always_ff @(posedge ck) begin
        if (push_store) begin
            data_mem[wr_ptr_q] <= in_data;
            mask_mem[wr_ptr_q] <= in_lane_en;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)        rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_store, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    if (SERIAL_OUT == 0) begin : g_vec

        assign out_valid     = (level_q != '0);
        assign pop           = out_valid & out_ready;
        assign out_lane_en   = out_valid ? head_mask : '0;
        assign out_last      = out_valid;
        assign out_lane_data = '0;
        assign out_lane_idx  = '0;

        always_comb begin
            out_data = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (out_valid && head_mask[k]) out_data[k] = head_data[k];
            end
        end

    end else begin : g_ser

        fsm_e                 state_q, state_d;
        logic [IW-1:0]        lane_q, lane_d;
        logic                 last_q, last_d;
        logic                 hs;
        logic                 advance;
        logic [NUM_LANES-1:0] nxt_head_mask;
        logic [NUM_LANES-1:0] pick_mask;
        logic [IW-1:0]        pick_start;
        logic                 pick_found;
        logic [IW-1:0]        pick_idx;
        logic                 pick_last;

        assign out_valid = (state_q == EMIT);
        assign hs        = out_valid & out_ready;
        assign pop       = hs & last_q;
        assign advance   = (state_q == EMIT) && !last_q;

        // The head after this edge: still in memory unless the FIFO drains,
        // in which case it can only be the entry being written right now.
        assign nxt_head_mask = ((level_q != '0) && !(pop && (level_q == LW'(1))))
                             ? mask_mem[rd_ptr_d] : in_lane_en;

        // One picker: either step within the head, or find the first lane of
        // the next head. last_q is registered so out_last needs no second search.
        assign pick_mask  = advance ? head_mask : nxt_head_mask;
        assign pick_start = advance ? lane_q : '0;

        abc_lane_pick #(
            .NUM_LANES (NUM_LANES)
        ) u_pick (
            .mask      (pick_mask),
            .start_idx (pick_start),
            .incl      (!advance),
            .found     (pick_found),
            .idx       (pick_idx),
            .is_last   (pick_last)
        );

        always_comb begin
            state_d = state_q;
            lane_d  = lane_q;
            last_d  = last_q;
            unique case (state_q)
                IDLE: begin
                    if (level_d != '0) begin
                        state_d = EMIT;
                        lane_d  = pick_idx;
                        last_d  = pick_last;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (!last_q || (level_d != '0)) begin
                            lane_d = pick_idx;
                            last_d = pick_last;
                        end else begin
                            state_d = IDLE;
                            lane_d  = '0;
                            last_d  = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge ck) begin
            if (!rst_n) begin
                state_q <= IDLE;
                lane_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                lane_q  <= lane_d;
                last_q  <= last_d;
            end
        end

        assign out_data      = '0;
        assign out_lane_en   = out_valid ? head_mask : '0;
        assign out_lane_idx  = out_valid ? lane_q : '0;
        assign out_lane_data = out_valid ? head_data[lane_q] : '0;
        assign out_last      = out_valid & last_q;

        logic unused_found;
        assign unused_found = pick_found;

    end

endmodule

// File: tb/tb_abc_vec_fifo.sv
module tb_abc_vec_fifo;
    import abc_vec_pkg::*;

    localparam int NL    = 6;
    localparam int LWD   = 32;
    localparam int DEPTH = 4;

    typedef logic [NL-1:0][LWD-1:0] vec_t;
    typedef struct {
        vec_t            data;
        logic [NL-1:0]   mask;
    } ent_t;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    vec_t          in_data;
    logic [NL-1:0] in_lane_en;

    logic          in_ready0, out_valid0, out_last0;
    vec_t          out_data0;
    logic [NL-1:0] out_lane_en0;
    logic [31:0]   out_lane_data0;
    logic [2:0]    out_lane_idx0;
    logic [2:0]    level0;

    logic          in_ready1, out_valid1, out_last1;
    vec_t          out_data1;
    logic [NL-1:0] out_lane_en1;
    logic [31:0]   out_lane_data1;
    logic [2:0]    out_lane_idx1;
    logic [2:0]    level1;

    abc_vec_fifo #(.NUM_LANES(NL), .LANE_W(LWD), .DEPTH(DEPTH), .SERIAL_OUT(0)) u_dut0 (
        .ck(ck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_lane_en(in_lane_en), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_lane_en(out_lane_en0),
        .out_lane_data(out_lane_data0), .out_lane_idx(out_lane_idx0),
        .out_last(out_last0), .level(level0)
    );

    abc_vec_fifo #(.NUM_LANES(NL), .LANE_W(LWD), .DEPTH(DEPTH), .SERIAL_OUT(1)) u_dut1 (
        .ck(ck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_lane_en(in_lane_en), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_lane_en(out_lane_en1),
        .out_lane_data(out_lane_data1), .out_lane_idx(out_lane_idx1),
        .out_last(out_last1), .level(level1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int cnt_set(input logic [NL-1:0] m);
        int c = 0;
        for (int i = 0; i < NL; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int nth_set(input logic [NL-1:0] m, input int n);
        int c = 0;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic vec_t masked(input vec_t d, input logic [NL-1:0] m);
        vec_t r = '0;
        for (int k = 0; k < NL; k++) if (m[k]) r[k] = d[k];
        return r;
    endfunction

    // Reference model: one queue of entries per FIFO, plus which enabled lane
    // of the serial head is currently presented.
    ent_t q0[$];
    ent_t q1[$];
    int   pos1 = 0;
    bit   live = 1'b0;
    int   dhs1 = 0;
    logic [NL-1:0] seen1 = '0;

    always @(posedge ck) begin
        ent_t e;
        int   s0, s1;
        if (out_valid1 === 1'b1 && out_ready) begin
            dhs1++;
            seen1[out_lane_idx1] = 1'b1;
        end
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            pos1 = 0;
            live = 1'b1;
        end else if (live) begin
            e.data = in_data;
            e.mask = in_lane_en;
            s0 = q0.size();
            s1 = q1.size();
            if (s0 != 0 && out_ready) void'(q0.pop_front());
            if (in_valid && s0 != DEPTH) q0.push_back(e);
            if (s1 != 0 && out_ready) begin
                if (pos1 == cnt_set(q1[0].mask) - 1) begin
                    void'(q1.pop_front());
                    pos1 = 0;
                end else begin
                    pos1++;
                end
            end
            if (in_valid && s1 != DEPTH && in_lane_en != '0) q1.push_back(e);
        end
    end

    logic        pv1 = 1'b0, pr1 = 1'b0, prst = 1'b0;
    logic [31:0] pd1;
    logic [2:0]  pi1;

    always @(negedge ck) begin
        int ix;
        if (live) begin
            chk("d0_level", 192'(level0), 192'(q0.size()));
            chk("d0_in_ready", 192'(in_ready0), 192'(q0.size() != DEPTH));
            chk("d0_out_valid", 192'(out_valid0), 192'(q0.size() != 0));
            if (q0.size() != 0) begin
                chk("d0_out_data", 192'(out_data0), 192'(masked(q0[0].data, q0[0].mask)));
                chk("d0_lane_en", 192'(out_lane_en0), 192'(q0[0].mask));
                chk("d0_out_last", 192'(out_last0), 192'(1));
            end else begin
                chk("d0_out_data_idle", 192'(out_data0), 192'(0));
                chk("d0_lane_en_idle", 192'(out_lane_en0), 192'(0));
            end
            chk("d1_level", 192'(level1), 192'(q1.size()));
            chk("d1_in_ready", 192'(in_ready1), 192'(q1.size() != DEPTH));
            chk("d1_out_valid", 192'(out_valid1), 192'(q1.size() != 0));
            if (q1.size() != 0) begin
                ix = nth_set(q1[0].mask, pos1);
                chk("d1_lane_idx", 192'(out_lane_idx1), 192'(ix));
                chk("d1_lane_data", 192'(out_lane_data1), 192'(q1[0].data[ix]));
                chk("d1_out_last", 192'(out_last1), 192'(pos1 == cnt_set(q1[0].mask) - 1));
                chk("d1_lane_en", 192'(out_lane_en1), 192'(q1[0].mask));
            end else begin
                chk("d1_lane_idx_idle", 192'(out_lane_idx1), 192'(0));
                chk("d1_lane_data_idle", 192'(out_lane_data1), 192'(0));
                chk("d1_out_last_idle", 192'(out_last1), 192'(0));
                chk("d1_lane_en_idle", 192'(out_lane_en1), 192'(0));
            end
            if (pv1 && !pr1 && prst && rst_n) begin
                chk("d1_stall_data", 192'(out_lane_data1), 192'(pd1));
                chk("d1_stall_idx", 192'(out_lane_idx1), 192'(pi1));
            end
            pv1  = out_valid1;
            pr1  = out_ready;
            prst = rst_n;
            pd1  = out_lane_data1;
            pi1  = out_lane_idx1;
        end
    end

    task automatic step();
        @(posedge ck);
        #2;
    endtask

    task automatic set_vec(input logic [31:0] base);
        for (int k = 0; k < NL; k++) in_data[k] = base + 32'(k);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_hs;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        in_lane_en = '0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_level0", 192'(level0), 192'(0));
        chk("rst_valid0", 192'(out_valid0), 192'(0));
        chk("rst_data0", 192'(out_data0), 192'(0));
        chk("rst_last0", 192'(out_last0), 192'(0));
        chk("rst_en0", 192'(out_lane_en0), 192'(0));
        chk("rst_valid1", 192'(out_valid1), 192'(0));
        chk("rst_ldata1", 192'(out_lane_data1), 192'(0));
        chk("rst_idx1", 192'(out_lane_idx1), 192'(0));
        chk("rst_last1", 192'(out_last1), 192'(0));
        chk("rst_level1", 192'(level1), 192'(0));

        // single vector, whole-vector and serial views
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_lane_en = 6'h3F;
        set_vec(32'h1000_0000);
        step();
        in_valid = 1'b0;
        chk("t1_valid", 192'(out_valid0), 192'(1));
        chk("t1_data", 192'(out_data0),
            192'h10000005_10000004_10000003_10000002_10000001_10000000);
        chk("t1_last", 192'(out_last0), 192'(1));
        chk("t1_level", 192'(level0), 192'(1));
        chk("t1_ser_idx", 192'(out_lane_idx1), 192'(0));
        chk("t1_ser_data", 192'(out_lane_data1), 192'(32'h1000_0000));
        chk("t1_ser_last", 192'(out_last1), 192'(0));
        step();
        chk("t1_level_after", 192'(level0), 192'(0));
        chk("t1_valid_after", 192'(out_valid0), 192'(0));
        repeat (5) step();
        chk("t1_ser_drained", 192'(level1), 192'(0));
        reset_pulse();

        // fill to full, then drain with continued push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int v = 0; v < 5; v++) begin
            set_vec(32'hA000_0000 + 32'(v * 16));
            chk("t2_in_ready", 192'(in_ready0), 192'(v < 4));
            step();
        end
        chk("t2_level_full", 192'(level0), 192'(4));
        chk("t2_in_ready_full", 192'(in_ready0), 192'(0));
        out_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            chk("t2_order", 192'(out_data0[0]), 192'(32'hA000_0000 + 32'(p * 16)));
            step();
            if (p == 1) in_valid = 1'b0;
        end
        chk("t2_empty", 192'(level0), 192'(0));
        reset_pulse();

        // serial lanes 0,3,5 then a single-lane entry with no bubble
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_lane_en = 6'b101001;
        set_vec(32'hB000_0000);
        step();
        in_lane_en = 6'h01;
        set_vec(32'hC000_0000);
        chk("t3_idx_a", 192'(out_lane_idx1), 192'(0));
        chk("t3_data_a", 192'(out_lane_data1), 192'(32'hB000_0000));
        chk("t3_last_a", 192'(out_last1), 192'(0));
        step();
        in_valid = 1'b0;
        chk("t3_idx_b", 192'(out_lane_idx1), 192'(3));
        chk("t3_data_b", 192'(out_lane_data1), 192'(32'hB000_0003));
        chk("t3_last_b", 192'(out_last1), 192'(0));
        step();
        chk("t3_idx_c", 192'(out_lane_idx1), 192'(5));
        chk("t3_data_c", 192'(out_lane_data1), 192'(32'hB000_0005));
        chk("t3_last_c", 192'(out_last1), 192'(1));
        chk("t3_level_c", 192'(level1), 192'(2));
        step();
        chk("t3_valid_d", 192'(out_valid1), 192'(1));
        chk("t3_idx_d", 192'(out_lane_idx1), 192'(0));
        chk("t3_data_d", 192'(out_lane_data1), 192'(32'hC000_0000));
        chk("t3_last_d", 192'(out_last1), 192'(1));
        step();
        chk("t3_valid_e", 192'(out_valid1), 192'(0));
        chk("t3_level_e", 192'(level1), 192'(0));

        // all-zero mask: accepted by serial FIFO, but nothing stored
        in_valid   = 1'b1;
        in_lane_en = 6'h00;
        set_vec($urandom);
        chk("t4_in_ready", 192'(in_ready1), 192'(1));
        step();
        in_valid = 1'b0;
        chk("t4_level", 192'(level1), 192'(0));
        chk("t4_valid", 192'(out_valid1), 192'(0));
        chk("t4_vec_valid", 192'(out_valid0), 192'(1));
        chk("t4_vec_data", 192'(out_data0), 192'(0));
        step();

        // backpressure toggling during one serial entry
        in_valid   = 1'b1;
        in_lane_en = 6'h3F;
        set_vec(32'hD000_0000);
        step();
        in_valid = 1'b0;
        base_hs  = dhs1;
        seen1    = '0;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c % 2 == 1);
            step();
        end
        chk("t5_beats", 192'(dhs1 - base_hs), 192'(6));
        chk("t5_lanes", 192'(seen1), 192'(6'h3F));
        chk("t5_level", 192'(level1), 192'(0));
        reset_pulse();

        // reset in the middle of a serial entry
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_lane_en = 6'h3F;
        for (int v = 0; v < 3; v++) begin
            set_vec(32'hE000_0000 + 32'(v * 16));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("t6_pre_level", 192'(level1), 192'(3));
        chk("t6_pre_idx", 192'(out_lane_idx1), 192'(4));
        rst_n = 1'b0;
        step();
        chk("t6_level", 192'(level1), 192'(0));
        chk("t6_valid", 192'(out_valid1), 192'(0));
        chk("t6_ldata", 192'(out_lane_data1), 192'(0));
        chk("t6_idx", 192'(out_lane_idx1), 192'(0));
        chk("t6_last", 192'(out_last1), 192'(0));
        chk("t6_en", 192'(out_lane_en1), 192'(0));
        chk("t6_level0", 192'(level0), 192'(0));
        chk("t6_data0", 192'(out_data0), 192'(0));
        rst_n      = 1'b1;
        in_valid   = 1'b1;
        in_lane_en = 6'b110100;
        set_vec(32'hF000_0000);
        step();
        in_valid = 1'b0;
        chk("t6_post_idx", 192'(out_lane_idx1), 192'(2));
        chk("t6_post_data", 192'(out_lane_data1), 192'(32'hF000_0002));
        chk("t6_post_last", 192'(out_last1), 192'(0));
        repeat (4) step();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_lane_en = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
            for (int k = 0; k < NL; k++) in_data[k] = $urandom;
            out_ready  = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
